// File: rtl/bsg_muxi2_gatestack_pipe_pkg.sv
// Shared constants and buffer-operation encoding for the buffered inverting-mux pipe.
package bsg_muxi2_gatestack_pipe_pkg;

  localparam int width_default_c = 16;

  // What the 2-entry buffer does on a given edge: {enq, deq}
  typedef enum logic [1:0] {
    op_idle = 2'b00,
    op_deq  = 2'b01,
    op_enq  = 2'b10,
    op_both = 2'b11
  } buf_op_t;

endpackage

// File: rtl/bsg_muxi2_gatestack.sv
// Per-bit inverting 2:1 select: o[b] = ~(i2[b] ? i1[b] : i0[b]).
module bsg_muxi2_gatestack #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] i0,
  input  logic [width_p-1:0] i1,
  input  logic [width_p-1:0] i2,
  output logic [width_p-1:0] o
);

  for (genvar b = 0; b < width_p; b++) begin : g_bit
    assign o[b] = ~(i2[b] ? i1[b] : i0[b]);
  end

endmodule

// File: rtl/bsg_muxi2_gatestack_pipe.sv
// Valid/ready-in, valid/yumi-out wrapper that computes the gatestack result on entry
// and holds up to two results in a small pointer-based buffer.
module bsg_muxi2_gatestack_pipe
  import bsg_muxi2_gatestack_pipe_pkg::*;
#(
  parameter int width_p            = width_default_c,
  parameter int restore_polarity_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data0_i,
  input  logic [width_p-1:0] data1_i,
  input  logic [width_p-1:0] sel_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  // Handshake: a triple transfers on an edge where v_i & ready_o; a result leaves
  // on an edge where yumi_i is high, which downstream may only assert while v_o=1.

  logic [width_p-1:0] gate_r;
  logic [width_p-1:0] result;

  bsg_muxi2_gatestack #(.width_p(width_p)) gatestack (
    .i0 (data0_i),
    .i1 (data1_i),
    .i2 (sel_i),
    .o  (gate_r)
  );

  if (restore_polarity_p != 0) begin : g_restore
    assign result = ~gate_r;
  end else begin : g_raw
    assign result = gate_r;
  end

  logic [width_p-1:0] mem [2];
  logic               wptr_r, rptr_r;
  logic               full_r, empty_r;
  logic               enq, deq;
  buf_op_t            op;

  assign ready_o = ~full_r & ~reset_i;
  assign v_o     = ~empty_r;
  assign data_o  = mem[rptr_r];

  // A yumi against an empty buffer is masked so state stays intact.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & ~empty_r & ~reset_i;
  assign op  = buf_op_t'({enq, deq});

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= result;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      // Pointer equality after the move is ambiguous; the operation says which flag it means.
      case (op)
        op_enq: begin
          empty_r <= 1'b0;
          full_r  <= (~wptr_r == rptr_r);
        end
        op_deq: begin
          full_r  <= 1'b0;
          empty_r <= (~rptr_r == wptr_r);
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && empty_r))
        else $error("bsg_muxi2_gatestack_pipe: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_muxi2_gatestack_pipe.sv
// Directed and random checks of the buffered inverting-mux pipe against a queue model.
module tb_bsg_muxi2_gatestack_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_i, v_i, yumi_i;
  logic [W-1:0] data0, data1, sel;
  logic         ready_o, v_o, ready_raw, v_raw;
  logic [W-1:0] data_o, data_raw;

  always #5 clk = ~clk;

  bsg_muxi2_gatestack_pipe #(.width_p(W), .restore_polarity_p(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .data0_i(data0), .data1_i(data1), .sel_i(sel),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  bsg_muxi2_gatestack_pipe #(.width_p(W), .restore_polarity_p(0)) dut_raw (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_raw),
    .data0_i(data0), .data1_i(data1), .sel_i(sel),
    .v_o(v_raw), .data_o(data_raw), .yumi_i(yumi_i)
  );

  // Scoreboard: true (non-inverted) mux values, in acceptance order.
  logic [W-1:0] exp_q[$];
  logic         cur_rst;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, b, s);
    return (s & b) | (~s & a);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Sample on the falling edge and compare both instances with the model.
  task automatic wait_check(input string tag);
    logic exp_v, exp_ready;
    @(negedge clk);
    exp_v     = (exp_q.size() > 0);
    exp_ready = !cur_rst && (exp_q.size() < 2);
    chk({tag, " v_o"},       W'(v_o),       W'(exp_v));
    chk({tag, " ready_o"},   W'(ready_o),   W'(exp_ready));
    chk({tag, " raw v_o"},   W'(v_raw),     W'(exp_v));
    chk({tag, " raw ready"}, W'(ready_raw), W'(exp_ready));
    if (exp_v) begin
      chk({tag, " data_o"},   data_o,   exp_q[0]);
      chk({tag, " raw data"}, data_raw, ~exp_q[0]);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic y,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    logic enq, deq;
    reset_i = rst; v_i = v; yumi_i = y;
    data0 = a; data1 = b; sel = s;
    enq = v && !rst && (exp_q.size() < 2);
    deq = y && !rst && (exp_q.size() > 0);
    cur_rst = rst;
    if (rst) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(ref_mux(a, b, s));
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic y,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    wait_check(tag);
    drive(rst, v, y, a, b, s);
  endtask

  logic [W-1:0] ra, rb, rs;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    data0 = '0; data1 = '0; sel = '0;
    cur_rst = 1'b1;
    @(posedge clk);

    // Reset held, then released.
    step("reset", 1'b1, 1'b0, 1'b0, '0, '0, '0);
    step("reset", 1'b1, 1'b0, 1'b0, '0, '0, '0);
    step("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step("idle",  1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Single transfer with known answers.
    step("single", 1'b0, 1'b1, 1'b0, 16'h00FF, 16'hF0F0, 16'h0F0F);
    wait_check("single out");
    chk("single true", data_o, 16'h00F0);
    chk("single raw", data_raw, 16'hFF0F);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Fill to full; third triple held until a yumi frees a slot.
    step("fill a", 1'b0, 1'b1, 1'b0, 16'h1234, 16'hABCD, 16'hFF00);
    step("fill b", 1'b0, 1'b1, 1'b0, 16'h5555, 16'hAAAA, 16'h0FF0);
    wait_check("full");
    chk("full ready", W'(ready_o), W'(1'b0));
    drive(1'b0, 1'b1, 1'b0, 16'hC0DE, 16'hBEEF, 16'h3C3C);
    step("held", 1'b0, 1'b1, 1'b1, 16'hC0DE, 16'hBEEF, 16'h3C3C);
    step("accept", 1'b0, 1'b1, 1'b0, 16'hC0DE, 16'hBEEF, 16'h3C3C);
    step("drain", 1'b0, 1'b0, 1'b1, '0, '0, '0);
    step("drain", 1'b0, 1'b0, 1'b1, '0, '0, '0);
    step("drain", 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Streaming with random operands, yumi whenever a result is present.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = W'($urandom);
      step("stream", 1'b0, 1'b1, exp_q.size() > 0, ra, rb, rs);
    end
    step("stream end", 1'b0, 1'b0, 1'b1, '0, '0, '0);
    step("stream idle", 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Reset with a full buffer: buffered results must vanish.
    step("pre rst", 1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h00FF);
    step("pre rst", 1'b0, 1'b1, 1'b0, 16'h3333, 16'h4444, 16'hFF00);
    step("mid rst", 1'b1, 1'b1, 1'b1, 16'h9999, 16'h9999, 16'h9999);
    wait_check("post rst");
    chk("post rst v_o", W'(v_o), W'(1'b0));
    drive(1'b0, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 16'hF00F);
    wait_check("first after rst");
    chk("first after rst data", data_o, ref_mux(16'hA5A5, 16'h5A5A, 16'hF00F));
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Simultaneous enqueue and yumi with one entry.
    step("enq a", 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF);
    step("enq b deq a", 1'b0, 1'b1, 1'b1, 16'h6789, 16'h1357, 16'h00FF);
    wait_check("both");
    chk("both data", data_o, ref_mux(16'h6789, 16'h1357, 16'h00FF));
    chk("both v_o", W'(v_o), W'(1'b1));
    chk("both ready", W'(ready_o), W'(1'b1));
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step("final", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    wait_check("final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
